// File: rtl/imem_pkg.sv
// Shared types, widths and the byte-merge helper for the instruction memory block.
package imem_pkg;

    localparam int IMEM_BLOCK_BITS     = 128;
    localparam int IMEM_ADDR_BITS      = 6;
    localparam int IMEM_BYTE_ADDR_BITS = 10;
    localparam int IMEM_CNT_BITS       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } imem_state_e;

    // Replace one little-endian byte lane of a block.
    function automatic logic [IMEM_BLOCK_BITS-1:0] imem_merge_byte(
        input logic [IMEM_BLOCK_BITS-1:0] blk,
        input logic [3:0]                 lane,
        input logic [7:0]                 data
    );
        logic [IMEM_BLOCK_BITS-1:0] merged;
        merged = blk;
        merged[{lane, 3'b000} +: 8] = data;
        return merged;
    endfunction

endpackage

// File: rtl/imem_block_ctrl_if.sv
// Cache-side read/busywait handshake plus the byte-wide program-load port.
interface imem_block_ctrl_if;
    import imem_pkg::*;

    logic                           read;
    logic [IMEM_ADDR_BITS-1:0]      address;
    logic [IMEM_BLOCK_BITS-1:0]     readdata;
    logic                           busywait;
    logic                           prog_we;
    logic [IMEM_BYTE_ADDR_BITS-1:0] prog_addr;
    logic [7:0]                     prog_data;

    modport master (
        output read, address, prog_we, prog_addr, prog_data,
        input  readdata, busywait
    );

    modport slave (
        input  read, address, prog_we, prog_addr, prog_data,
        output readdata, busywait
    );
endinterface

// File: rtl/imem_latency_timer.sv
// Loadable 4-bit down-counter; expired flags a zero count.
module imem_latency_timer
    import imem_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     load,
    input  logic [IMEM_CNT_BITS-1:0] load_value,
    input  logic                     dec,
    output logic                     expired
);

    logic [IMEM_CNT_BITS-1:0] count_r;

    // Count register: load has priority, decrement saturates at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= load_value;
        end else if (dec && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == 4'd0);

endmodule

// File: rtl/imem_block_ctrl.sv
// Block-organised instruction memory with programmable read latency and a byte program-load port.
module imem_block_ctrl
    import imem_pkg::*;
#(
    parameter int READ_LATENCY = 5,
    parameter int BLOCK_BITS   = 128,
    parameter int NUM_BLOCKS   = 64
)(
    input  logic               clock,
    input  logic               reset,
    imem_block_ctrl_if.slave   bus
);

    if ((READ_LATENCY < 1) || (READ_LATENCY > 15)) begin : g_bad_latency
        $error("imem_block_ctrl: READ_LATENCY must be within 1..15");
    end
    if ((BLOCK_BITS != IMEM_BLOCK_BITS) || (NUM_BLOCKS != (1 << IMEM_ADDR_BITS))) begin : g_bad_geometry
        $error("imem_block_ctrl: only 64 blocks of 128 bits are supported");
    end

    localparam logic [IMEM_CNT_BITS-1:0] LOAD_VALUE = IMEM_CNT_BITS'(READ_LATENCY - 1);

    imem_state_e                state_r;
    imem_state_e                state_nxt_s;
    logic [IMEM_ADDR_BITS-1:0]  addr_r;
    logic [IMEM_BLOCK_BITS-1:0] readdata_r;
    logic [IMEM_BLOCK_BITS-1:0] mem_r [(1 << IMEM_ADDR_BITS)];
    logic [IMEM_BLOCK_BITS-1:0] captured_s;
    logic                       write_hit_s;
    logic                       timer_load_s;
    logic                       timer_dec_s;
    logic                       capture_s;
    logic                       busy_s;
    logic                       expired_s;

    imem_latency_timer u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load_s),
        .load_value (LOAD_VALUE),
        .dec        (timer_dec_s),
        .expired    (expired_s)
    );

    // Next-state and handshake decode; busywait is deliberately combinational.
    always_comb begin
        state_nxt_s  = state_r;
        timer_load_s = 1'b0;
        timer_dec_s  = 1'b0;
        capture_s    = 1'b0;
        busy_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.read) begin
                    busy_s       = 1'b1;
                    timer_load_s = 1'b1;
                    state_nxt_s  = BUSY;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            BUSY: begin
                busy_s = 1'b1;
                if (expired_s) begin
                    capture_s   = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    timer_dec_s = 1'b1;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latch the block address at acceptance; later address changes are ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_r <= 6'd0;
        end else if (timer_load_s) begin
            addr_r <= bus.address;
        end else begin
            addr_r <= addr_r;
        end
    end

    // A program write landing on the capture edge must be visible in the captured block.
    always_comb begin
        write_hit_s = bus.prog_we && (bus.prog_addr[9:4] == addr_r);
        if (write_hit_s) begin
            captured_s = imem_merge_byte(mem_r[addr_r], bus.prog_addr[3:0], bus.prog_data);
        end else begin
            captured_s = mem_r[addr_r];
        end
    end

    // Returned block register, held until the next capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata_r <= 128'd0;
        end else if (capture_s) begin
            readdata_r <= captured_s;
        end else begin
            readdata_r <= readdata_r;
        end
    end

    // Memory array: never cleared, and a write coinciding with reset is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (!reset && bus.prog_we) begin
            mem_r[bus.prog_addr[9:4]] <= imem_merge_byte(mem_r[bus.prog_addr[9:4]],
                                                         bus.prog_addr[3:0], bus.prog_data);
        end
    end

    assign bus.readdata = readdata_r;
    assign bus.busywait = busy_s;

endmodule

// File: tb/tb_imem_block_ctrl.sv
// Directed-plus-random bench for imem_block_ctrl at latencies 5, 1 and 15 against a byte-array model.
module tb_imem_block_ctrl;

    logic         clock;
    logic         reset;
    logic         rq [3];
    logic [5:0]   ad [3];
    logic         pwe;
    logic [9:0]   pad;
    logic [7:0]   pdat;
    logic         bw [3];
    logic [127:0] rdv [3];
    logic [7:0]   mem_m [1024];
    int           checks;
    int           errors;

    imem_block_ctrl_if if0 ();
    imem_block_ctrl_if if1 ();
    imem_block_ctrl_if if2 ();

    assign if0.read = rq[0];  assign if0.address = ad[0];
    assign if1.read = rq[1];  assign if1.address = ad[1];
    assign if2.read = rq[2];  assign if2.address = ad[2];
    assign if0.prog_we = pwe; assign if0.prog_addr = pad; assign if0.prog_data = pdat;
    assign if1.prog_we = pwe; assign if1.prog_addr = pad; assign if1.prog_data = pdat;
    assign if2.prog_we = pwe; assign if2.prog_addr = pad; assign if2.prog_data = pdat;
    assign bw[0] = if0.busywait; assign rdv[0] = if0.readdata;
    assign bw[1] = if1.busywait; assign rdv[1] = if1.readdata;
    assign bw[2] = if2.busywait; assign rdv[2] = if2.readdata;

    imem_block_ctrl #(.READ_LATENCY(5))  u_d5  (.clock(clock), .reset(reset), .bus(if0));
    imem_block_ctrl #(.READ_LATENCY(1))  u_d1  (.clock(clock), .reset(reset), .bus(if1));
    imem_block_ctrl #(.READ_LATENCY(15)) u_d15 (.clock(clock), .reset(reset), .bus(if2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected block assembled from the byte model: lane l holds byte address {a, l}.
    function automatic logic [127:0] model_block(input logic [5:0] a);
        logic [127:0] r;
        r = 128'd0;
        for (int l = 0; l < 16; l++) r[8*l +: 8] = mem_m[int'(a) * 16 + l];
        return r;
    endfunction

    task automatic write_byte(input logic [9:0] a, input logic [7:0] d);
        @(negedge clock);
        pwe = 1'b1; pad = a; pdat = d;
        @(posedge clock);
        mem_m[a] = d;
    endtask

    // Called at a negedge: raises read, then counts busy cycles after acceptance until DONE.
    task automatic do_read(input int k, input logic [5:0] a, input int drop_at, input logic [5:0] a2,
                           input int pw_at, input logic [9:0] pw_a, input logic [7:0] pw_d,
                           output int n);
        rq[k] = 1'b1; ad[k] = a;
        #1;
        check("busy_same_cycle", 128'(bw[k]), 128'(1'b1));
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            if (pwe) mem_m[pad] = pdat;
            @(negedge clock);
            pwe = 1'b0;
            #1;
            if (!bw[k]) break;
            n++;
            if (n == 1) ad[k] = a2;
            if (n >= drop_at) rq[k] = 1'b0;
            if (n == pw_at) begin pwe = 1'b1; pad = pw_a; pdat = pw_d; end
        end
    endtask

    initial begin
        int          n;
        logic [5:0]  blk;
        logic [7:0]  nb;
        logic [127:0] hold;
        checks = 0; errors = 0;
        reset = 1'b1; pwe = 1'b0; pad = 10'd0; pdat = 8'd0;
        for (int k = 0; k < 3; k++) begin rq[k] = 1'b0; ad[k] = 6'd0; end

        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        for (int k = 0; k < 3; k++) begin
            check("reset_busy", 128'(bw[k]), 128'd0);
            check("reset_rdata", rdv[k], 128'd0);
        end
        reset = 1'b0;

        for (int i = 0; i < 1024; i++) write_byte(10'(i), (i < 16) ? 8'(i) : 8'($urandom));
        @(negedge clock); pwe = 1'b0;

        // Second reset: program must survive.
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check("reset2_busy", 128'(bw[0]), 128'd0);
        check("reset2_rdata", rdv[0], 128'd0);
        reset = 1'b0;

        @(negedge clock);
        do_read(0, 6'd0, 1, 6'd0, 0, 10'd0, 8'd0, n);
        check("single_busy_cycles", 128'(n), 128'd5);
        check("single_rdata", rdv[0], 128'h0F0E0D0C_0B0A0908_07060504_03020100);
        check("single_word2", 128'(rdv[0][95:64]), 128'(32'h0B0A0908));

        @(negedge clock);
        do_read(0, 6'd3, 1, 6'd9, 0, 10'd0, 8'd0, n);
        check("hold_busy_cycles", 128'(n), 128'd5);
        check("hold_rdata", rdv[0], model_block(6'd3));
        hold = model_block(6'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            check("hold_stable", rdv[0], hold);
        end

        @(negedge clock);
        do_read(0, 6'd5, 99, 6'd5, 0, 10'd0, 8'd0, n);
        check("b2b_first_cycles", 128'(n), 128'd5);
        check("b2b_first_rdata", rdv[0], model_block(6'd5));
        ad[0] = 6'd6;
        @(negedge clock); #1;
        check("b2b_idle_rdata", rdv[0], model_block(6'd5));
        do_read(0, 6'd6, 1, 6'd6, 0, 10'd0, 8'd0, n);
        check("b2b_second_cycles", 128'(n), 128'd5);
        check("b2b_second_rdata", rdv[0], model_block(6'd6));

        @(negedge clock);
        do_read(0, 6'd7, 2, 6'd7, 0, 10'd0, 8'd0, n);
        check("abort_cycles", 128'(n), 128'd5);
        check("abort_rdata", rdv[0], model_block(6'd7));
        @(negedge clock); #1;
        check("abort_idle_busy", 128'(bw[0]), 128'd0);

        @(negedge clock);
        rq[0] = 1'b1; ad[0] = 6'd10;
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b1; rq[0] = 1'b0;
        #1;
        check("midreset_busy", 128'(bw[0]), 128'd0);
        check("midreset_rdata", rdv[0], 128'd0);
        @(negedge clock); reset = 1'b0;
        repeat (8) @(negedge clock);
        #1;
        check("midreset_no_capture", rdv[0], 128'd0);
        check("midreset_idle_busy", 128'(bw[0]), 128'd0);

        for (int i = 0; i < 4; i++) begin
            blk = 6'($urandom_range(63));
            @(negedge clock);
            do_read(0, blk, 1, 6'($urandom_range(63)), 0, 10'd0, 8'd0, n);
            check("rand_cycles", 128'(n), 128'd5);
            check("rand_rdata", rdv[0], model_block(blk));
        end

        blk = 6'($urandom_range(63));
        @(negedge clock);
        do_read(1, blk, 1, blk, 0, 10'd0, 8'd0, n);
        check("lat1_cycles", 128'(n), 128'd1);
        check("lat1_rdata", rdv[1], model_block(blk));

        blk = 6'($urandom_range(63));
        nb  = mem_m[int'(blk) * 16 + 15] ^ 8'($urandom_range(254) + 1);
        @(negedge clock);
        do_read(2, blk, 1, blk, 15, {blk, 4'hF}, nb, n);
        check("lat15_cycles", 128'(n), 128'd15);
        check("lat15_lane15", 128'(rdv[2][127:120]), 128'(nb));
        check("lat15_rdata", rdv[2], model_block(blk));

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
